clk_div_gen: RTL and testbench

Clock-derivation stage that sits directly downstream of the bench's 100 MHz master clock and produces the derived 50 MHz and 25 MHz square waves, plus a run-time programmable divide-by-N output with a period-start tick. Every output is a flop output (glitch-free) clocked by the master clock. Consumers are the multi-rate blocks and benches that currently generate their own slower clocks with free-running delay loops.

---
 rtl/clk_div_pkg.sv | 5 +
 rtl/clk_div_phase.sv | 56 +++++
 rtl/clk_div_gen.sv | 92 +++++++++
 tb/tb_clk_div_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_gen clock-derivation block.
package clk_div_pkg;
  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;
  localparam int DIV_MIN = 2;
endpackage

// File: rtl/clk_div_phase.sv
// Divide-by-N phase generator: divisor/pending registers, phase counter, clk_divn and tick_n flops.
// Outputs follow the edge after the phase they describe; a new divisor only takes effect at a period boundary.
module clk_div_phase
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             set_pend,
  input  logic             apply,
  input  logic [CNT_W-1:0] value,
  output logic             boundary,
  output logic             clk_divn,
  output logic             tick_n
);

  logic [CNT_W-1:0] divisor;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pc;

  assign boundary = (pc == divisor - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor  <= CNT_W'(DIV_DEFAULT);
      pending  <= '0;
      pc       <= '0;
      clk_divn <= 1'b0;
      tick_n   <= 1'b0;
    end else begin
      if (load) begin
        divisor <= value;
      end else if (apply) begin
        divisor <= pending;
      end
      if (set_pend) begin
        pending <= value;
      end
      // apply only fires on a boundary or on stop, so pc is already heading to 0
      if (en) begin
        pc       <= boundary ? '0 : pc + CNT_W'(1);
        clk_divn <= (pc < (divisor >> 1));
        tick_n   <= (pc == '0);
      end else begin
        pc       <= '0;
        clk_divn <= 1'b0;
        tick_n   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Derives clk/2, clk/4 and a programmable clk/N (with period-start tick) from the master clock.
// All outputs registered; divisor port stalls (div_ready=0) while a change waits for the period boundary.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             div_err,
  output logic             clk_div2,
  output logic             clk_div4,
  output logic             clk_divn,
  output logic             tick_n
);

  state_t     state;
  logic [1:0] q2;
  logic       xfer;
  logic       val_ok;
  logic       load;
  logic       set_pend;
  logic       apply;
  logic       boundary;

  assign xfer     = div_valid && div_ready;
  assign val_ok   = (div_value >= CNT_W'(DIV_MIN));
  // while stopped (or stopping) there is no period to protect, so load at once
  assign load     = xfer && val_ok && ((state == STOP) || !en);
  assign set_pend = xfer && val_ok && (state == RUN) && en;
  assign apply    = (state == PEND) && (!en || boundary);

  assign clk_div2 = q2[0];
  assign clk_div4 = q2[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STOP;
      q2        <= 2'd0;
      div_ready <= 1'b1;
      div_err   <= 1'b0;
    end else begin
      div_err <= xfer && !val_ok;
      q2      <= en ? q2 + 2'd1 : 2'd0;
      case (state)
        STOP: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= STOP;
          end else if (set_pend) begin
            state     <= PEND;
            div_ready <= 1'b0;
          end
        end
        PEND: begin
          if (apply) begin
            state     <= en ? RUN : STOP;
            div_ready <= 1'b1;
          end
        end
        default: begin
          state     <= STOP;
          div_ready <= 1'b1;
        end
      endcase
    end
  end

  clk_div_phase #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .set_pend(set_pend),
    .apply   (apply),
    .value   (div_value),
    .boundary(boundary),
    .clk_divn(clk_divn),
    .tick_n  (tick_n)
  );

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic against a behavioural model.
module tb_clk_div_gen;
  localparam int CNT_W       = 8;
  localparam int DIV_DEFAULT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_valid;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             div_err;
  logic             clk_div2;
  logic             clk_div4;
  logic             clk_divn;
  logic             tick_n;
  logic [5:0]       obs;

  int checks = 0;
  int errors = 0;

  // behavioural model: enabled-edge count, position within the current period, divisor, pending queue
  int  m_n, m_pos, m_k;
  int  pend[$];
  bit  m_ready, m_run, m_err, m_divn, m_tick;

  clk_div_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_valid(div_valid),
    .div_value(div_value),
    .div_ready(div_ready),
    .div_err  (div_err),
    .clk_div2 (clk_div2),
    .clk_div4 (clk_div4),
    .clk_divn (clk_divn),
    .tick_n   (tick_n)
  );

  always #5 clk = ~clk;

  assign obs = {clk_div2, clk_div4, clk_divn, tick_n, div_ready, div_err};

  function automatic logic [5:0] exp_vec();
    return {(m_k % 2) == 1, (m_k % 4) >= 2, m_divn, m_tick, m_ready, m_err};
  endfunction

  task automatic model_reset();
    m_n = DIV_DEFAULT; m_pos = 0; m_k = 0;
    pend.delete();
    m_ready = 1'b1; m_run = 1'b0; m_err = 1'b0; m_divn = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int val);
    bit xfer, ok, fresh, pend_end;
    xfer  = v && m_ready;
    ok    = (val >= 2);
    m_err = xfer && !ok;
    fresh = 1'b0;
    if (!e) begin
      if (xfer && ok) m_n = val;
      else if (pend.size() > 0) m_n = pend[0];
      pend.delete();
      m_k = 0; m_pos = 0; m_divn = 1'b0; m_tick = 1'b0; m_ready = 1'b1; m_run = 1'b0;
    end else begin
      m_divn   = (m_pos < m_n / 2);
      m_tick   = (m_pos == 0);
      m_k++;
      pend_end = (m_pos == m_n - 1);
      m_pos    = pend_end ? 0 : m_pos + 1;
      if (xfer && ok) begin
        if (!m_run) m_n = val;
        else begin
          pend.push_back(val);
          m_ready = 1'b0;
          fresh   = 1'b1;
        end
      end
      if (pend_end && !fresh && pend.size() > 0) begin
        m_n     = pend.pop_front();
        m_ready = 1'b1;
      end
      m_run = 1'b1;
    end
  endtask

  // drive at the falling edge, let one rising edge happen, return at the next falling edge
  task automatic cyc(input bit e, input bit v, input int val);
    en        = e;
    div_valid = v;
    div_value = val[CNT_W-1:0];
    @(posedge clk);
    model_edge(e, v, val);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 6'b000010) begin
      errors++; $display("FAIL reset_hold got %b want %b", obs, 6'b000010);
    end
    rst = 1'b1;
    model_reset();
    cyc(0, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_default();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL default_model cyc %0d got %b want %b", i, obs, exp_vec());
      end
      checks++;
      if (obs[5:2] !== {(i % 2) == 1, (i % 4) >= 2, ((i - 1) % 4) < 2, ((i - 1) % 4) == 0}) begin
        errors++; $display("FAIL default_pattern cyc %0d got %b", i, obs[5:2]);
      end
    end
  endtask

  task automatic test_stop_load();
    cyc(0, 0, 0);
    cyc(0, 1, 5);
    checks++;
    if (obs !== 6'b000010) begin
      errors++; $display("FAIL stop_load_idle got %b want %b", obs, 6'b000010);
    end
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 0, 0);
      checks++;
      if ({clk_divn, tick_n, div_ready} !== {((i - 1) % 5) < 2, ((i - 1) % 5) == 0, 1'b1}) begin
        errors++; $display("FAIL stop_load_n5 cyc %0d got %b", i, {clk_divn, tick_n, div_ready});
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL stop_load_model cyc %0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_change();
    int e;
    cyc(0, 1, 4);
    cyc(1, 0, 0);
    cyc(1, 1, 6);
    checks++;
    if (div_ready !== 1'b0) begin
      errors++; $display("FAIL change_ready_drop got %b want 0", div_ready);
    end
    for (int j = 1; j <= 20; j++) begin
      cyc(1, 0, 0);
      e = j + 2;
      checks++;
      if ({clk_divn, tick_n, div_ready} !==
          {(e >= 5) && (((e - 5) % 6) < 3), (e >= 5) && (((e - 5) % 6) == 0), j >= 2}) begin
        errors++; $display("FAIL change_seq edge %0d got %b", e, {clk_divn, tick_n, div_ready});
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL change_model edge %0d got %b want %b", e, obs, exp_vec());
      end
    end
  endtask

  task automatic test_err();
    cyc(1, 1, 1);
    checks++;
    if ({div_err, div_ready} !== 2'b11) begin
      errors++; $display("FAIL err_one got %b want 11", {div_err, div_ready});
    end
    cyc(1, 0, 0);
    checks++;
    if (div_err !== 1'b0) begin
      errors++; $display("FAIL err_width got %b want 0", div_err);
    end
    cyc(1, 1, 0);
    checks++;
    if ({div_err, div_ready} !== 2'b11) begin
      errors++; $display("FAIL err_zero got %b want 11", {div_err, div_ready});
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL err_model cyc %0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_en_drop();
    cyc(1, 1, 8);
    checks++;
    if (div_ready !== 1'b0) begin
      errors++; $display("FAIL drop_pend got %b want 0", div_ready);
    end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if (obs !== 6'b000010) begin
      errors++; $display("FAIL drop_stop got %b want %b", obs, 6'b000010);
    end
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 0, 0);
      checks++;
      if ({clk_divn, tick_n} !== {((i - 1) % 8) < 4, ((i - 1) % 8) == 0}) begin
        errors++; $display("FAIL drop_n8 cyc %0d got %b", i, {clk_divn, tick_n});
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL drop_model cyc %0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_rst_mid();
    cyc(1, 0, 0);
    cyc(1, 1, 12);
    cyc(1, 0, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000010) begin
      errors++; $display("FAIL rst_async got %b want %b", obs, 6'b000010);
    end
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 0);
      checks++;
      if ({clk_divn, tick_n} !== {((i - 1) % DIV_DEFAULT) < 2, ((i - 1) % DIV_DEFAULT) == 0}) begin
        errors++; $display("FAIL rst_default cyc %0d got %b", i, {clk_divn, tick_n});
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rst_model cyc %0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit e, v;
    int val;
    for (int i = 0; i < 1500; i++) begin
      e   = ($urandom_range(0, 24) != 0);
      v   = ($urandom_range(0, 3) == 0);
      val = $urandom_range(0, 11);
      cyc(e, v, val);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    div_valid = 1'b0;
    div_value = '0;
    model_reset();
    test_reset();
    test_default();
    test_stop_load();
    test_change();
    test_err();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
